// File: rtl/hexdisplay_scan.sv
// Multiplexed common-anode 7-segment hex driver with guard interval, PWM dimming,
// leading-zero suppression and a per-frame input snapshot.
module hexdisplay_scan #(
   parameter int DIGITS      = 4,
   parameter int SLOT_CYCLES = 524288,
   parameter int GUARD       = 16,
   parameter int BW          = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  lzs,
   input  logic [BW-1:0]         bright,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_tick
);

   localparam int PW = $clog2(SLOT_CYCLES);
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [PW-1:0]          pcnt;
   logic [DW-1:0]          dig;
   logic [BW-1:0]          pwm;
   logic                   frame_start;

   logic [4*DIGITS-1:0]    value_s;
   logic [DIGITS-1:0]      dp_s;
   logic [DIGITS-1:0]      blank_s;
   logic                   lzs_s;
   logic [BW-1:0]          bright_s;

   logic [3:0]             nib;
   logic                   dp_cur;
   logic                   blank_cur;
   logic                   hi_nz;
   logic                   supp;
   logic [7:0]             seg_p0;
   logic [DIGITS-1:0]      an_p0;

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'h40;
         4'h1: hex_glyph = 7'h79;
         4'h2: hex_glyph = 7'h24;
         4'h3: hex_glyph = 7'h30;
         4'h4: hex_glyph = 7'h19;
         4'h5: hex_glyph = 7'h12;
         4'h6: hex_glyph = 7'h02;
         4'h7: hex_glyph = 7'h78;
         4'h8: hex_glyph = 7'h00;
         4'h9: hex_glyph = 7'h10;
         4'ha: hex_glyph = 7'h08;
         4'hb: hex_glyph = 7'h03;
         4'hc: hex_glyph = 7'h46;
         4'hd: hex_glyph = 7'h21;
         4'he: hex_glyph = 7'h06;
         default: hex_glyph = 7'h0E;
      endcase
   endfunction

   assign frame_start = (pcnt == '0) && (dig == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt <= '0;
         dig  <= '0;
         pwm  <= '0;
      end else begin
         pwm <= pwm + BW'(1);
         if (pcnt == PW'(SLOT_CYCLES - 1)) begin
            pcnt <= '0;
            dig  <= (dig == DW'(DIGITS - 1)) ? '0 : dig + DW'(1);
         end else begin
            pcnt <= pcnt + PW'(1);
         end
      end
   end

   // Snapshot is taken only at frame start so a frame is never torn by input changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_s  <= '0;
         dp_s     <= '0;
         blank_s  <= '1;
         lzs_s    <= 1'b0;
         bright_s <= '0;
      end else if (frame_start) begin
         value_s  <= value;
         dp_s     <= dp;
         blank_s  <= blank;
         lzs_s    <= lzs;
         bright_s <= bright;
      end
   end

   always_comb begin
      nib       = 4'h0;
      dp_cur    = 1'b0;
      blank_cur = 1'b1;
      hi_nz     = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig == DW'(i)) begin
            nib       = value_s[4*i +: 4];
            dp_cur    = dp_s[i];
            blank_cur = blank_s[i];
         end
         if (i >= int'(dig) && value_s[4*i +: 4] != 4'h0)
            hi_nz = 1'b1;
      end
      supp = lzs_s && (dig != '0) && !hi_nz;
   end

   // p0: decode current slot into next seg/an; a suppressed digit keeps its anode only for dp.
   always_comb begin
      seg_p0 = 8'hFF;
      an_p0  = '1;
      if (pcnt >= PW'(GUARD) && pwm <= bright_s && !blank_cur && !(supp && !dp_cur)) begin
         an_p0  = ~(DIGITS'(1) << dig);
         seg_p0 = {~dp_cur, supp ? 7'h7F : hex_glyph(nib)};
      end
   end

   // p1: registered pin outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         seg        <= 8'hFF;
         an         <= '1;
         frame_tick <= 1'b0;
      end else begin
         seg        <= seg_p0;
         an         <= an_p0;
         frame_tick <= frame_start;
      end
   end

endmodule

// File: tb/tb_hexdisplay_scan.sv
// Scoreboard bench for hexdisplay_scan: a cycle-count reference model predicts
// every output cycle; a monitor pops and compares on the falling edge.
module tb_hexdisplay_scan;

   localparam int DIGITS = 4;
   localparam int SLOT   = 8;
   localparam int GUARD  = 1;
   localparam int BW     = 2;
   localparam int FRAME  = SLOT * DIGITS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic [3:0]  blank = '0;
   logic        lzs = 1'b0;
   logic [1:0]  bright = 2'd3;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame_tick;

   always #5 clk = ~clk;

   hexdisplay_scan #(
      .DIGITS(DIGITS), .SLOT_CYCLES(SLOT), .GUARD(GUARD), .BW(BW)
   ) dut (
      .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank),
      .lzs(lzs), .bright(bright), .seg(seg), .an(an), .frame_tick(frame_tick)
   );

   typedef struct packed {
      logic [7:0] seg;
      logic [3:0] an;
      logic       ft;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   logic [6:0] glyph [16];
   initial glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model: position in the scan is derived purely from cycles since reset.
   int          t = 0;
   int          mp, md, mw;
   logic [15:0] mv;
   logic [3:0]  mdp, mbl, mnib;
   logic        mlz, msup;
   logic [1:0]  mbr;
   exp_t        e;

   always @(posedge clk) begin
      e = '{seg: 8'hFF, an: 4'hF, ft: 1'b0};
      if (rst) begin
         t = 0; mv = '0; mdp = '0; mbl = '1; mlz = 1'b0; mbr = '0;
      end else begin
         mp = t % SLOT;
         md = (t / SLOT) % DIGITS;
         mw = t % (1 << BW);
         if (t % FRAME == 0) begin
            mv = value; mdp = dp; mbl = blank; mlz = lzs; mbr = bright;
         end
         e.ft = (t % FRAME == 0);
         mnib = 4'((mv >> (4 * md)) & 16'hF);
         msup = mlz && (md != 0) && ((mv >> (4 * md)) == 16'h0);
         if (mp >= GUARD && mw <= int'(mbr) && !mbl[md] && !(msup && !mdp[md])) begin
            e.an  = ~(4'b0001 << md);
            e.seg = {~mdp[md], msup ? 7'h7F : glyph[mnib]};
         end
         t++;
      end
      sbq.push_back(e);
   end

   exp_t got;
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         got = sbq.pop_front();
         tests++;
         if ({seg, an, frame_tick} !== {got.seg, got.an, got.ft}) begin
            fails++;
            $display("FAIL outputs @%0t: actual seg=%h an=%b ft=%b, required seg=%h an=%b ft=%b",
                     $time, seg, an, frame_tick, got.seg, got.an, got.ft);
         end
         tests++;
         if (!$onehot0(~an)) begin
            fails++;
            $display("FAIL anode_onehot @%0t: actual an=%b, required at most one low bit", $time, an);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      cyc(3);
      // digits 0..3 show F,3,A,1 at full brightness
      value = 16'h1A3F; bright = 2'd3; lzs = 1'b0; dp = 4'b0000; blank = 4'b0000;
      rst = 1'b0;
      cyc(2 * FRAME);
      // leading-zero suppression with a dp on a suppressed digit, then all-zero value
      value = 16'h0005; lzs = 1'b1; dp = 4'b0100;
      cyc(2 * FRAME);
      value = 16'h0000;
      cyc(2 * FRAME);
      // mid-frame change must not tear the current frame
      value = 16'h1111; lzs = 1'b0; dp = 4'b0000;
      cyc(FRAME + 10);
      value = 16'h2222;
      cyc(2 * FRAME);
      // PWM duty steps
      value = 16'h8C4E;
      bright = 2'd0; cyc(2 * FRAME);
      bright = 2'd1; cyc(2 * FRAME);
      bright = 2'd2; cyc(FRAME);
      // blanking
      bright = 2'd3; blank = 4'b1010; cyc(2 * FRAME);
      blank = 4'b0000;
      // reset during digit 2
      cyc(FRAME + 2 * SLOT + 3);
      rst = 1'b1; cyc(1); rst = 1'b0;
      cyc(FRAME + 8);
      // randomized traffic with occasional resets
      repeat (80) begin
         value  = 16'($urandom);
         if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
         dp     = 4'($urandom);
         blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         lzs    = 1'($urandom);
         bright = 2'($urandom);
         if ($urandom_range(0, 11) == 0) begin
            rst = 1'b1; cyc($urandom_range(1, 3)); rst = 1'b0;
         end
         cyc($urandom_range(1, 45));
      end
      cyc(4);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hexdisplay_scan.md
Name: hexdisplay_scan

Overview:
- Parametrised multiplexed 7-segment hex driver. Scans DIGITS common-anode digits.
- Adds these features:
  - per-digit decimal point
  - per-digit blanking
  - leading-zero suppression
  - PWM brightness
  - an anode-off guard interval between digits (anti-ghosting)
  - tear-free frame snapshot of the inputs
- Sits between register/debug logic and the board's seg/an pins.

Parameters:
- DIGITS, 4, number of digits scanned; 1..8.
- SLOT_CYCLES, 524288, clk cycles each digit is selected; must be >= GUARD+2.
- GUARD, 16, cycles at the start of each slot with all anodes off; 1..SLOT_CYCLES-2.
- BW, 4, brightness width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- value  in  4*DIGITS  hex digits; digit i displays value[4i+3:4i]; digit DIGITS-1 is most significant.
- dp  in  DIGITS  decimal point enable per digit, active-high.
- blank  in  DIGITS  force digit fully dark (anode never driven), active-high.
- lzs  in  1  leading-zero suppression enable.
- bright  in  BW  brightness; duty is (bright+1)/2^BW.
- seg  out  8  active-low segments: seg[0]=a, seg[1]=b, ..., seg[6]=g, seg[7]=dp.
- an  out  DIGITS  active-low anodes; an[i] selects digit i.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Counters:
  - Slot counter pcnt runs 0..SLOT_CYCLES-1 and wraps.
  - Digit index dig advances on each pcnt wrap: 0,1,...,DIGITS-1,0.
  - Frame start is the cycle with pcnt==0 and dig==0.
- Snapshot:
  - At every frame start, value, dp, blank, lzs and bright are captured into snapshot registers.
  - All display decisions use the snapshot only. Input changes mid-frame never alter the current frame.
- Outputs are registered, with 1 cycle latency: seg/an at cycle t+1 reflect pcnt/dig/snapshot at cycle t.
- Guard: while pcnt < GUARD, an is all ones and seg is 8'hFF.
- PWM:
  - A free-running BW-bit counter pwm increments every cycle and is reset to 0.
  - Outside the guard interval, the digit is lit only while pwm <= bright.
  - bright = all-ones gives 100% duty.
- Suppression: digit i is suppressed when all of the following hold:
  - lzs = 1
  - i != 0
  - every nibble j >= i is 0
- Lit digit (not guard, PWM on, not blanked):
  - an = ~(1<<dig).
  - seg[6:0] = hex glyph of the nibble, or 7'h7F if suppressed.
  - seg[7] = ~dp[dig].
- A suppressed digit with dp=0 drives no anode (an all ones). With dp=1 it drives its anode with only the dp segment lit.
- Blanked digit, or PWM off: an all ones, seg 8'hFF.
- Glyphs, active-low {g..a}:

  | Digit | Value | Digit | Value | Digit | Value | Digit | Value |
  |-------|-------|-------|-------|-------|-------|-------|-------|
  | 0 | 40 | 4 | 19 | 8 | 00 | c | 46 |
  | 1 | 79 | 5 | 12 | 9 | 10 | d | 21 |
  | 2 | 24 | 6 | 02 | a | 08 | e | 06 |
  | 3 | 30 | 7 | 78 | b | 03 | f | 0E |

- frame_tick is registered: it is high for exactly the one cycle after the frame-start cycle, i.e. aligned with the first output cycle of digit 0.
- Reset (sync, rst=1):
  - pcnt=0, dig=0, pwm=0.
  - an = all ones, seg = 8'hFF, frame_tick = 0.
  - Snapshot cleared: value=0, dp=0, blank=all ones, lzs=0, bright=0.
- After reset release:
  - The first cycle is a frame start, so the snapshot loads immediately.
  - Because GUARD>=1, no stale data is ever shown.
  - Reset asserted mid-slot takes effect on the next edge. No partial digit is completed.
- Exactly one anode bit may be low at any time; never two.

Test Plan (DIGITS=4, SLOT_CYCLES=8, GUARD=1, BW=2 unless noted):
1. Reset, then value=16'h1A3F, bright=3, lzs=0:
   - digit 0 slot: an=1110, seg=8'h8E for 7 cycles after 1 guard cycle.
   - digits 1..3 follow with an 1101/1011/0111 and seg 8'hB0/8'h88/8'hF9.
   - frame_tick pulses every 32 cycles.
2. value=16'h0005, lzs=1, dp=4'b0100:
   - digits 3 and 1 are never driven.
   - digit 2 shows an=1011, seg=8'h7F (dp only).
   - digit 0 shows seg=8'h92.
   - value=0 with lzs=1 still shows "0" on digit 0.
3. Change value from 16'h1111 to 16'h2222 mid-frame (during digit 1):
   - digits 1..3 still show "1" for the rest of the frame.
   - all digits show "2" from the next frame_tick.
4. bright=0:
   - within each non-guard slot, the anode is low only on cycles where pwm==0 (1 in 4).
   - bright=1 gives 2 of 4.
   - never two anodes low at once.
5. blank=4'b1010:
   - an[1] and an[3] stay high for the whole frame.
   - seg=8'hFF during those slots.
6. Assert rst during digit 2:
   - the next cycle has an=all ones, seg=8'hFF, frame_tick=0.
   - after release, the digit 0 slot starts immediately with the guard cycle.
